// File: rtl/mul_seq_unit.sv
// Sequential 32x32 RV32M multiplier (MUL/MULH/MULHSU/MULHU) built around a
// radix-2 shift-add loop feeding a 32-bit ripple-carry adder.

module mul_seq_rca #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] sum_o,
  output logic            cout_o
);

  logic [XLEN:0] w_carry;

  assign w_carry[0] = 1'b0;

  // One full adder per bit; the carry ripples LSB to MSB within a cycle.
  for (genvar g = 0; g < XLEN; g++) begin : g_fa
    assign sum_o[g]       = a_i[g] ^ b_i[g] ^ w_carry[g];
    assign w_carry[g + 1] = (a_i[g] & b_i[g]) | (w_carry[g] & (a_i[g] ^ b_i[g]));
  end

  assign cout_o = w_carry[XLEN];

endmodule

module mul_seq_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CW = $clog2(ITER);
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_mq;
  logic [XLEN-1:0]   r_acc;
  logic [CW-1:0]     r_cnt;
  logic              r_neg;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_lastIter;
  logic              w_rs1Signed;
  logic              w_rs2Signed;
  logic              w_rs1Neg;
  logic              w_rs2Neg;
  logic [XLEN-1:0]   w_mcandIn;
  logic [XLEN-1:0]   w_mqIn;
  logic [XLEN-1:0]   w_addB;
  logic [XLEN-1:0]   w_sum;
  logic              w_cout;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prodFixed;

  assign w_accept   = (r_state == S_IDLE) && valid_i && !flush_i;
  assign w_lastIter = (r_cnt == CW'(ITER - 1));

  // rs1 is unsigned only for MULHU; rs2 is unsigned for MULHSU and MULHU.
  assign w_rs1Signed = (op_i != OP_MULHU);
  assign w_rs2Signed = !op_i[1];
  assign w_rs1Neg    = w_rs1Signed & rs1_i[XLEN-1];
  assign w_rs2Neg    = w_rs2Signed & rs2_i[XLEN-1];
  assign w_mcandIn   = w_rs1Neg ? (~rs1_i + 1'b1) : rs1_i;
  assign w_mqIn      = w_rs2Neg ? (~rs2_i + 1'b1) : rs2_i;

  assign w_addB = r_mq[0] ? r_mcand : '0;

  mul_seq_rca #(
    .XLEN (XLEN)
  ) u_rca (
    .a_i    (r_acc),
    .b_i    (w_addB),
    .sum_o  (w_sum),
    .cout_o (w_cout)
  );

  assign w_prod      = {r_acc, r_mq};
  assign w_prodFixed = r_neg ? (~w_prod + 1'b1) : w_prod;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Flush overrides every transition, including the DONE handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (valid_i) w_next = S_CALC;
      S_CALC: if (w_lastIter) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush_i) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mcand  <= '0;
      r_mq     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_op     <= OP_MUL;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand <= w_mcandIn;
            r_mq    <= w_mqIn;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= w_rs1Neg ^ w_rs2Neg;
            r_op    <= op_i;
          end
        end
        S_CALC: begin
          if (!flush_i) begin
            // 65-bit right shift of {cout, sum, mq}.
            r_acc <= {w_cout, w_sum[XLEN-1:1]};
            r_mq  <= {w_sum[0], r_mq[XLEN-1:1]};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (!flush_i) begin
            r_result <= (r_op == OP_MUL) ? w_prodFixed[XLEN-1:0]
                                         : w_prodFixed[2*XLEN-1:XLEN];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ready_o  = (r_state == S_IDLE);
  assign busy_o   = (r_state != S_IDLE);
  assign valid_o  = (r_state == S_DONE);
  assign result_o = r_result;

endmodule
